// File: rtl/process_frame_core.sv
// process_frame_core: per-flow asynchronous traffic shaper (token-bucket style)
// eligibility-time calculator. One frame is processed at a time through a
// fixed IDLE -> CALC1 -> CALC2 -> CALC3 -> OUT sequence.
// Optional build macro PROCESS_FRAME_CORE_MAX_RESIDENCE_CHECK_EN enables the
// max-residence-time discard check; without it every eligibility time is
// accepted and max_residence_time is ignored.
module process_frame_core #(
  parameter int DATA_WIDTH         = 8,
  parameter int FLOW_NUM           = 16,
  parameter int FLOW_WIDTH         = 8,
  parameter int TIMESTAMP_WIDTH    = 72,
  parameter int FRAME_LENGTH_WIDTH = 16,
  parameter int COMMIT_VALUE_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_information_rate_inv_0,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_information_rate_inv_1,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_information_rate_inv_2,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_information_rate_inv_3,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_information_rate_inv_4,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_information_rate_inv_5,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_information_rate_inv_6,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_information_rate_inv_7,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_information_rate_inv_8,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_information_rate_inv_9,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_information_rate_inv_10,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_information_rate_inv_11,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_information_rate_inv_12,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_information_rate_inv_13,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_information_rate_inv_14,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_information_rate_inv_15,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_burst_size_0,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_burst_size_1,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_burst_size_2,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_burst_size_3,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_burst_size_4,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_burst_size_5,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_burst_size_6,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_burst_size_7,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_burst_size_8,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_burst_size_9,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_burst_size_10,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_burst_size_11,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_burst_size_12,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_burst_size_13,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_burst_size_14,
  input  logic [COMMIT_VALUE_WIDTH-1:0] committed_burst_size_15,
  input  logic [TIMESTAMP_WIDTH-1:0]    max_residence_time,
  input  logic [TIMESTAMP_WIDTH-1:0]    s_axis_arrival_timestamp_tdata,
  input  logic                          s_axis_arrival_timestamp_tvalid,
  output logic                          s_axis_arrival_timestamp_tready,
  input  logic [FLOW_WIDTH-1:0]         s_axis_flow_tdata,
  input  logic                          s_axis_flow_tvalid,
  output logic                          s_axis_flow_tready,
  input  logic [FRAME_LENGTH_WIDTH-1:0] s_axis_frame_length_tdata,
  input  logic                          s_axis_frame_length_tvalid,
  output logic                          s_axis_frame_length_tready,
  output logic [TIMESTAMP_WIDTH-1:0]    m_axis_eligibility_timestamp_tdata,
  output logic                          m_axis_eligibility_timestamp_tvalid,
  input  logic                          m_axis_eligibility_timestamp_tready
);

  localparam int TSW     = TIMESTAMP_WIDTH;
  localparam int CVW     = COMMIT_VALUE_WIDTH;
  localparam int FLW     = FRAME_LENGTH_WIDTH;
  localparam int CFG_NUM = 16;
  localparam int IDX_W   = (FLOW_NUM > 1) ? $clog2(FLOW_NUM) : 1;
  localparam logic [FLOW_WIDTH:0] FLOW_LIMIT = (FLOW_WIDTH+1)'(FLOW_NUM);

  typedef enum logic [2:0] {IDLE, CALC1, CALC2, CALC3, OUT} state_t;

  function automatic logic [TSW-1:0] sat_add(input logic [TSW-1:0] a, input logic [TSW-1:0] b);
    logic [TSW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[TSW] ? {TSW{1'b1}} : s[TSW-1:0];
  endfunction

  state_t state, state_next;

  logic [CVW-1:0] cir_inv [CFG_NUM];
  logic [CVW-1:0] cbs     [CFG_NUM];

  logic [TSW-1:0]        arrival_q, len_rec_q, e2f_q, sched_q, full_q, elig_q, out_q;
  logic [FLOW_WIDTH-1:0] flow_q;
  logic [FLW-1:0]        len_q;
  logic [TSW-1:0]        bucket_empty [FLOW_NUM];
  logic [TSW-1:0]        group_elig   [FLOW_NUM];

  logic                  in_ready, accept, in_range, accept_elig;
  logic [3:0]            cfg_idx;
  logic [IDX_W-1:0]      st_idx;
  logic [FLW+CVW-1:0]    len_prod;
  logic [2*CVW-1:0]      e2f_prod;
  logic [TSW-1:0]        bucket_rd, group_rd, sched_c, full_c, elig_c, bucket_new;
  logic [TSW:0]          bucket_sum;

  assign cir_inv = '{committed_information_rate_inv_0,  committed_information_rate_inv_1,
                     committed_information_rate_inv_2,  committed_information_rate_inv_3,
                     committed_information_rate_inv_4,  committed_information_rate_inv_5,
                     committed_information_rate_inv_6,  committed_information_rate_inv_7,
                     committed_information_rate_inv_8,  committed_information_rate_inv_9,
                     committed_information_rate_inv_10, committed_information_rate_inv_11,
                     committed_information_rate_inv_12, committed_information_rate_inv_13,
                     committed_information_rate_inv_14, committed_information_rate_inv_15};
  assign cbs     = '{committed_burst_size_0,  committed_burst_size_1,  committed_burst_size_2,
                     committed_burst_size_3,  committed_burst_size_4,  committed_burst_size_5,
                     committed_burst_size_6,  committed_burst_size_7,  committed_burst_size_8,
                     committed_burst_size_9,  committed_burst_size_10, committed_burst_size_11,
                     committed_burst_size_12, committed_burst_size_13, committed_burst_size_14,
                     committed_burst_size_15};

  // Input join: all three streams are taken together, only while idle and out of reset.
  assign in_ready = (state == IDLE) && rstn;
  assign accept   = in_ready && s_axis_arrival_timestamp_tvalid
                    && s_axis_flow_tvalid && s_axis_frame_length_tvalid;
  assign s_axis_arrival_timestamp_tready = in_ready;
  assign s_axis_flow_tready              = in_ready;
  assign s_axis_frame_length_tready      = in_ready;
  assign m_axis_eligibility_timestamp_tvalid = (state == OUT);
  assign m_axis_eligibility_timestamp_tdata  = out_q;

  // Flows outside the state table bypass shaping; reads are gated so they never touch it.
  assign in_range  = ({1'b0, flow_q} < FLOW_LIMIT);
  assign cfg_idx   = flow_q[3:0];
  assign st_idx    = flow_q[IDX_W-1:0];
  assign bucket_rd = in_range ? bucket_empty[st_idx] : '0;
  assign group_rd  = in_range ? group_elig[st_idx]   : '0;
  assign len_prod  = {{CVW{1'b0}}, len_q} * {{FLW{1'b0}}, cir_inv[cfg_idx]};
  assign e2f_prod  = {{CVW{1'b0}}, cbs[cfg_idx]} * {{CVW{1'b0}}, cir_inv[cfg_idx]};

`ifdef PROCESS_FRAME_CORE_MAX_RESIDENCE_CHECK_EN
  assign accept_elig = (elig_q <= sat_add(arrival_q, max_residence_time));
`else
  logic unused_max_res;
  assign unused_max_res = ^max_residence_time;
  assign accept_elig    = 1'b1;
`endif

  // CALC2 arithmetic and the CALC3 bucket-empty update, all saturating.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    sched_c    = sat_add(bucket_rd, len_rec_q);
    full_c     = sat_add(bucket_rd, e2f_q);
    elig_c     = arrival_q;
    if (group_rd > elig_c) elig_c = group_rd;
    if (sched_c  > elig_c) elig_c = sched_c;
    bucket_sum = {1'b0, sched_q} + {1'b0, elig_q} - {1'b0, full_q};
    if (elig_q < full_q)      bucket_new = sched_q;
    else if (bucket_sum[TSW]) bucket_new = '1;
    else                      bucket_new = bucket_sum[TSW-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: fixed pipeline walk, waiting in OUT for the consumer.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = CALC1;
      CALC1:   state_next = CALC2;
      CALC2:   state_next = CALC3;
      CALC3:   state_next = OUT;
      OUT:     if (m_axis_eligibility_timestamp_tready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture frame, compute per stage, commit per-flow state in CALC3.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      arrival_q <= '0; flow_q <= '0; len_q <= '0;
      len_rec_q <= '0; e2f_q  <= '0; sched_q <= '0;
      full_q    <= '0; elig_q <= '0; out_q   <= '0;
      // NOTE: the shaper state table must start cleared, so it is reset explicitly and kept in flops.
      for (int i = 0; i < FLOW_NUM; i++) begin
        bucket_empty[i] <= '0;
        group_elig[i]   <= '0;
      end
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          arrival_q <= s_axis_arrival_timestamp_tdata;
          flow_q    <= s_axis_flow_tdata;
          len_q     <= s_axis_frame_length_tdata;
        end
        CALC1: begin
          len_rec_q <= TSW'(len_prod);
          e2f_q     <= TSW'(e2f_prod);
        end
        CALC2: begin
          sched_q <= sched_c;
          full_q  <= full_c;
          elig_q  <= elig_c;
        end
        CALC3: begin
          if (!in_range) begin
            out_q <= arrival_q;
          end else if (accept_elig) begin
            out_q                <= elig_q;
            group_elig[st_idx]   <= elig_q;
            bucket_empty[st_idx] <= bucket_new;
          end else begin
            out_q <= '1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_process_frame_core.sv
// tb_process_frame_core: directed scenarios plus randomized frames checked
// against a spec-level shaper model (per-flow bucket/group arrays, plain
// saturating arithmetic). Mirrors PROCESS_FRAME_CORE_MAX_RESIDENCE_CHECK_EN.
module tb_process_frame_core;

  localparam logic [71:0] TS_MAX = '1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] cir [16];
  logic [31:0] cbs [16];
  logic [71:0] max_res = '1;
  logic [71:0] arr_data = '0;
  logic        arr_valid = 1'b0, arr_ready;
  logic [7:0]  flow_data = '0;
  logic        flow_valid = 1'b0, flow_ready;
  logic [15:0] len_data = '0;
  logic        len_valid = 1'b0, len_ready;
  logic [71:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [71:0] m_bucket [16];
  logic [71:0] m_group  [16];

  always #5 clk = ~clk;

  process_frame_core dut (
    .clk(clk), .rstn(rstn),
    .committed_information_rate_inv_0(cir[0]),   .committed_information_rate_inv_1(cir[1]),
    .committed_information_rate_inv_2(cir[2]),   .committed_information_rate_inv_3(cir[3]),
    .committed_information_rate_inv_4(cir[4]),   .committed_information_rate_inv_5(cir[5]),
    .committed_information_rate_inv_6(cir[6]),   .committed_information_rate_inv_7(cir[7]),
    .committed_information_rate_inv_8(cir[8]),   .committed_information_rate_inv_9(cir[9]),
    .committed_information_rate_inv_10(cir[10]), .committed_information_rate_inv_11(cir[11]),
    .committed_information_rate_inv_12(cir[12]), .committed_information_rate_inv_13(cir[13]),
    .committed_information_rate_inv_14(cir[14]), .committed_information_rate_inv_15(cir[15]),
    .committed_burst_size_0(cbs[0]),   .committed_burst_size_1(cbs[1]),
    .committed_burst_size_2(cbs[2]),   .committed_burst_size_3(cbs[3]),
    .committed_burst_size_4(cbs[4]),   .committed_burst_size_5(cbs[5]),
    .committed_burst_size_6(cbs[6]),   .committed_burst_size_7(cbs[7]),
    .committed_burst_size_8(cbs[8]),   .committed_burst_size_9(cbs[9]),
    .committed_burst_size_10(cbs[10]), .committed_burst_size_11(cbs[11]),
    .committed_burst_size_12(cbs[12]), .committed_burst_size_13(cbs[13]),
    .committed_burst_size_14(cbs[14]), .committed_burst_size_15(cbs[15]),
    .max_residence_time(max_res),
    .s_axis_arrival_timestamp_tdata(arr_data), .s_axis_arrival_timestamp_tvalid(arr_valid),
    .s_axis_arrival_timestamp_tready(arr_ready),
    .s_axis_flow_tdata(flow_data), .s_axis_flow_tvalid(flow_valid), .s_axis_flow_tready(flow_ready),
    .s_axis_frame_length_tdata(len_data), .s_axis_frame_length_tvalid(len_valid),
    .s_axis_frame_length_tready(len_ready),
    .m_axis_eligibility_timestamp_tdata(m_data), .m_axis_eligibility_timestamp_tvalid(m_valid),
    .m_axis_eligibility_timestamp_tready(m_ready)
  );

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] sat(input logic [75:0] x);
    return (x > {4'b0, TS_MAX}) ? TS_MAX : x[71:0];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) begin
      m_bucket[i] = '0;
      m_group[i]  = '0;
    end
  endfunction

  // Eligibility time from the shaper rules, using the config currently driven.
  function automatic logic [71:0] model(input int flow, input int len, input logic [71:0] arrival);
    logic [75:0] len_rec, e2f;
    logic [71:0] sched, full, elig;
    if (flow >= 16) return arrival;
    len_rec = 76'(len) * 76'(cir[flow]);
    e2f     = 76'(cbs[flow]) * 76'(cir[flow]);
    sched   = sat(76'(m_bucket[flow]) + len_rec);
    full    = sat(76'(m_bucket[flow]) + e2f);
    elig    = arrival;
    if (m_group[flow] > elig) elig = m_group[flow];
    if (sched > elig) elig = sched;
`ifdef PROCESS_FRAME_CORE_MAX_RESIDENCE_CHECK_EN
    if (elig > sat(76'(arrival) + 76'(max_res))) return TS_MAX;
`endif
    m_group[flow] = elig;
    if (elig < full) m_bucket[flow] = sched;
    else             m_bucket[flow] = sat(76'(sched) + 76'(elig) - 76'(full));
    return elig;
  endfunction

  task automatic do_reset(input int n);
    @(negedge clk);
    rstn = 1'b0;
    repeat (n) @(negedge clk);
    check("rst_tready", {arr_ready, flow_ready, len_ready}, 0);
    check("rst_tvalid", m_valid, 0);
    check("rst_tdata", m_data, 0);
    rstn = 1'b1;
    model_clear();
    @(negedge clk);
    check("rel_tready", {arr_ready, flow_ready, len_ready}, 3'b111);
  endtask

  task automatic set_cfg(input logic [31:0] c, input logic [31:0] b);
    for (int i = 0; i < 16; i++) begin
      cir[i] = c;
      cbs[i] = b;
    end
  endtask

  // Presents one frame and returns at the negedge just after the accept edge.
  task automatic start_frame(input logic [7:0] f, input logic [15:0] l, input logic [71:0] a);
    int n = 0;
    @(negedge clk);
    flow_data = f; len_data = l; arr_data = a;
    arr_valid = 1'b1; flow_valid = 1'b1; len_valid = 1'b1;
    while (!(arr_ready && flow_ready && len_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 72'(n < 50), 1);
    @(negedge clk);
    arr_valid = 1'b0; flow_valid = 1'b0; len_valid = 1'b0;
  endtask

  task automatic finish_frame(input int stall, output logic [71:0] got);
    int lat = 1;
    bit bad = 0;
    while (!m_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 72'(lat), 4);
    got = m_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!m_valid || m_data !== got || arr_ready || flow_ready || len_ready) bad = 1;
    end
    if (stall > 0) check("stall_hold", 72'(bad), 0);
    m_ready = 1'b1;
    @(negedge clk);
    check("transfer_done", m_valid, 0);
  endtask

  task automatic run_frame(input logic [7:0] f, input logic [15:0] l, input logic [71:0] a,
                           input int stall, output logic [71:0] got);
    m_ready = (stall == 0);
    start_frame(f, l, a);
    finish_frame(stall, got);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [71:0] got, exp, t;
    bit stray;
    set_cfg(32'd1, 32'hFFFF_FFFF);
    model_clear();

    // Basic first frame after a long reset.
    do_reset(10);
    run_frame(8'd0, 16'd1514, 72'd1_000_000_000, 0, got);
    void'(model(0, 1514, 72'd1_000_000_000));
    check("s1_out", got, 72'd1_000_000_000);

    // Bucket-limited second frame and independent flow.
    do_reset(3);
    set_cfg(32'd8000, 32'd1000);
    run_frame(8'd0, 16'd1000, 72'd1_000_000_000, 0, got);
    void'(model(0, 1000, 72'd1_000_000_000));
    check("s2_f1", got, 72'd1_000_000_000);
    run_frame(8'd0, 16'd1000, 72'd1_000_001_000, 0, got);
    void'(model(0, 1000, 72'd1_000_001_000));
    check("s2_f2", got, 72'd1_008_000_000);
    run_frame(8'd1, 16'd1000, 72'd1_000_002_000, 0, got);
    void'(model(1, 1000, 72'd1_000_002_000));
    check("s2_flow1", got, 72'd1_000_002_000);

    // Residence limit: discard (when enabled) leaves state untouched.
    do_reset(3);
    max_res = 72'd1_000_000;
    run_frame(8'd0, 16'd1000, 72'd1_000_000_000, 0, got);
    void'(model(0, 1000, 72'd1_000_000_000));
    check("s3_f1", got, 72'd1_000_000_000);
    run_frame(8'd0, 16'd1000, 72'd1_000_001_000, 0, got);
    void'(model(0, 1000, 72'd1_000_001_000));
`ifdef PROCESS_FRAME_CORE_MAX_RESIDENCE_CHECK_EN
    check("s3_discard", got, TS_MAX);
`else
    check("s3_nodiscard", got, 72'd1_008_000_000);
`endif
    run_frame(8'd0, 16'd1000, 72'd2_000_000_000, 0, got);
    void'(model(0, 1000, 72'd2_000_000_000));
    check("s3_after", got, 72'd2_000_000_000);
    max_res = '1;

    // Back-pressure on the output for 20 cycles.
    exp = model(1, 100, 72'd3_000_000_000);
    run_frame(8'd1, 16'd100, 72'd3_000_000_000, 20, got);
    check("stall_out", got, exp);

    // Reset in CALC2 aborts the frame; next frame sees cleared state.
    set_cfg(32'd1, 32'hFFFF_FFFF);
    m_ready = 1'b1;
    start_frame(8'd0, 16'd1514, 72'd5_000_000_000);
    @(negedge clk);
    rstn = 1'b0;
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_valid) stray = 1;
    end
    rstn = 1'b1;
    model_clear();
    repeat (6) begin
      @(negedge clk);
      if (m_valid) stray = 1;
    end
    check("abort_no_output", 72'(stray), 0);
    run_frame(8'd0, 16'd1514, 72'd1_000_000_000, 0, got);
    void'(model(0, 1514, 72'd1_000_000_000));
    check("abort_next", got, 72'd1_000_000_000);

    // Out-of-range flow IDs pass arrival through.
    run_frame(8'd20, 16'd1000, 72'd7_777_777, 0, got);
    check("flow20", got, 72'd7_777_777);
    run_frame(8'd255, 16'd64, 72'd123, 0, got);
    check("flow255", got, 72'd123);

    // Saturation near the top of the timestamp range.
    cir[5] = 32'hFFFF_FFFF;
    cbs[5] = 32'hFFFF_FFFF;
    t = TS_MAX - 72'd5;
    exp = model(5, 16'hFFFF, t);
    run_frame(8'd5, 16'hFFFF, t, 0, got);
    check("sat_f1", got, exp);
    t = TS_MAX - 72'd4;
    exp = model(5, 16'hFFFF, t);
    run_frame(8'd5, 16'hFFFF, t, 0, got);
    check("sat_f2", got, exp);

    // Randomized frames against the reference model.
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      cir[i] = 32'($urandom_range(1, 20000));
      cbs[i] = 32'($urandom_range(0, 5000));
    end
    t = 72'd1_000_000_000;
    for (int n = 0; n < 60; n++) begin
      int f, l, st, k;
      k = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) begin
        cir[k] = 32'($urandom_range(1, 20000));
        cbs[k] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 5000));
      end
      case ($urandom_range(0, 2))
        0:       max_res = 72'd5_000_000;
        1:       max_res = 72'd50_000_000;
        default: max_res = '1;
      endcase
      f  = $urandom_range(0, 19);
      l  = $urandom_range(64, 1518);
      st = $urandom_range(0, 3);
      t  = t + 72'($urandom_range(0, 20_000_000));
      exp = model(f, l, t);
      run_frame(8'(f), 16'(l), t, st, got);
      check("rand", got, exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
